msg_upload_ser: RTL and testbench

- Parametrised message-to-flit upload serializer for the communication assist.
- Accepts whole request/reply messages of FLITS×FLIT_W bits into a small message queue.
- Streams each message into the ring upload FIFO one flit per accepted cycle, with head/body/tail control tags.
- Unlike the single-buffer 3-flit uploader, it buffers QDEPTH messages, so a new message can be accepted while one is uploading.

---
 rtl/msg_upload_ser_if.sv | 33 +++
 rtl/msg_upload_ser.sv | 96 +++++++++
 tb/tb_msg_upload_ser.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/msg_upload_ser_if.sv
// Message upload serializer bus.
// Source side: msg_in, v_msg_in (message offer), msg_rdy (queue can accept).
// Sink side:   fifo_rdy (upload FIFO can take a flit), flit_out, v_flit_out,
//              ctrl_out (00 idle, 01 head, 10 body, 11 tail).
// Status:      upload_busy (queue non-empty), msg_cnt (messages held).
// master = message source / upload FIFO side, slave = serializer.
interface msg_upload_ser_if #(
  parameter int FLIT_W = 16,
  parameter int FLITS  = 3,
  parameter int QDEPTH = 2
) ();
  localparam int CW = $clog2(QDEPTH + 1);

  logic [FLIT_W*FLITS-1:0] msg_in;
  logic                    v_msg_in;
  logic                    msg_rdy;
  logic                    fifo_rdy;
  logic [FLIT_W-1:0]       flit_out;
  logic                    v_flit_out;
  logic [1:0]              ctrl_out;
  logic                    upload_busy;
  logic [CW-1:0]           msg_cnt;

  modport master (
    output msg_in, v_msg_in, fifo_rdy,
    input  msg_rdy, flit_out, v_flit_out, ctrl_out, upload_busy, msg_cnt
  );

  modport slave (
    input  msg_in, v_msg_in, fifo_rdy,
    output msg_rdy, flit_out, v_flit_out, ctrl_out, upload_busy, msg_cnt
  );
endinterface

// File: rtl/msg_upload_ser.sv
// Message-to-flit upload serializer.
// Buffers up to QDEPTH whole messages (FLITS x FLIT_W bits, flit 0 in the MS
// slice) and streams the oldest one flit per cycle in which fifo_rdy is high,
// tagging head/body/tail on ctrl_out.
// Ports: clk, rst (synchronous, active-high), bus (msg_upload_ser_if.slave).
module msg_upload_ser #(
  parameter int FLIT_W = 16,
  parameter int FLITS  = 3,
  parameter int QDEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  msg_upload_ser_if.slave     bus
);
  localparam int SW = (FLITS  > 1) ? $clog2(FLITS)  : 1;
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [FLIT_W*FLITS-1:0] mem [QDEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [SW-1:0]           sel;
  logic [CW-1:0]           cnt;

  logic                    busy, push, send, last, pop;
  logic [FLIT_W*FLITS-1:0] head_entry;

  always_comb begin
    busy       = (cnt != '0);
    push       = bus.v_msg_in && bus.msg_rdy;
    send       = busy && bus.fifo_rdy;
    last       = (sel == SW'(FLITS - 1));
    pop        = send && last;
    head_entry = mem[rd_ptr];
  end

  // Message storage is not reset; only pointers and counters are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.msg_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      sel    <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(QDEPTH - 1)) ? '0 : wr_ptr + PW'(1);

      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      unique case (state)
        IDLE: begin
          if (push) state <= SEND;
        end
        SEND: begin
          if (send) begin
            if (last) begin
              sel    <= '0;
              rd_ptr <= (rd_ptr == PW'(QDEPTH - 1)) ? '0 : rd_ptr + PW'(1);
              // Drop back to IDLE only when the popped message was the last one
              // and nothing is arriving to replace it.
              if (!push && cnt == CW'(1)) state <= IDLE;
            end else begin
              sel <= sel + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.msg_rdy     = !rst && (cnt < CW'(QDEPTH));
    bus.v_flit_out  = send;
    bus.upload_busy = busy;
    bus.msg_cnt     = cnt;
    bus.flit_out    = '0;
    bus.ctrl_out    = 2'b00;
    if (busy) begin
      bus.flit_out = head_entry[FLIT_W*(FLITS-1-int'(sel)) +: FLIT_W];
      if (sel == '0)   bus.ctrl_out = 2'b01;
      else if (last)   bus.ctrl_out = 2'b11;
      else             bus.ctrl_out = 2'b10;
    end
  end
endmodule

// File: tb/tb_msg_upload_ser.sv
module tb_msg_upload_ser;
  localparam int FW = 16, FL = 3, QD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  msg_upload_ser_if #(.FLIT_W(FW), .FLITS(FL), .QDEPTH(QD)) bus ();
  msg_upload_ser #(.FLIT_W(FW), .FLITS(FL), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  msg_upload_ser_if #(.FLIT_W(8), .FLITS(4), .QDEPTH(3)) bus_b ();
  msg_upload_ser #(.FLIT_W(8), .FLITS(4), .QDEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int cmps = 0;
  int errs = 0;
  int cyc  = 0;

  // Reference model: a queue of whole messages plus the index of the flit
  // currently presented from the oldest one.
  logic [47:0] mq[$];
  int          fidx = 0;
  bit          last_acc;

  logic [63:0] got[$];
  int          got_t[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Check DUT A against the model mid-cycle, then advance the model across
  // the next rising edge.
  task automatic cycle();
    logic [63:0] ef;
    logic [1:0]  ec;
    bit          e_busy, e_rdy, e_v;
    @(negedge clk);
    if (rst) begin
      chk("rdy_in_rst", bus.msg_rdy, 0);
      mq.delete();
      fidx = 0;
      last_acc = 0;
    end else begin
      e_busy = (mq.size() != 0);
      e_rdy  = (mq.size() < QD);
      e_v    = e_busy && bus.fifo_rdy;
      ef = 0;
      ec = 2'b00;
      if (e_busy) begin
        ef = 64'(mq[0]);
        ef = (ef >> (FW * (FL - 1 - fidx))) & 64'hFFFF;
        ec = (fidx == 0) ? 2'b01 : (fidx == FL - 1) ? 2'b11 : 2'b10;
      end
      chk("msg_rdy", bus.msg_rdy, e_rdy);
      chk("v_flit_out", bus.v_flit_out, e_v);
      chk("flit_out", bus.flit_out, ef);
      chk("ctrl_out", bus.ctrl_out, ec);
      chk("upload_busy", bus.upload_busy, e_busy);
      chk("msg_cnt", bus.msg_cnt, mq.size());
      if (bus.v_flit_out === 1'b1) begin
        got.push_back(64'(bus.flit_out));
        got_t.push_back(cyc);
      end
      last_acc = bus.v_msg_in && e_rdy;
      if (e_v) begin
        if (fidx == FL - 1) begin
          void'(mq.pop_front());
          fidx = 0;
        end else begin
          fidx++;
        end
      end
      if (last_acc) mq.push_back(bus.msg_in);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_log();
    got.delete();
    got_t.delete();
  endtask

  logic [47:0] pend[$];
  logic [15:0] exp9[9];
  logic [47:0] rmsg;
  bit          rpend;

  initial begin
    rst = 1'b1;
    bus.msg_in = '0; bus.v_msg_in = 1'b0; bus.fifo_rdy = 1'b1;
    bus_b.msg_in = '0; bus_b.v_msg_in = 1'b0; bus_b.fifo_rdy = 1'b1;

    // Reset then idle defaults
    run(2);
    rst = 1'b0;
    run(3);
    chk("idle_ctrl", bus.ctrl_out, 0);
    chk("idle_cnt", bus.msg_cnt, 0);

    // Single message, fifo always ready
    clear_log();
    bus.msg_in = 48'hAAAA_BBBB_CCCC; bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    run(5);
    chk("single_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("single_f0", got[0], 64'hAAAA);
      chk("single_f1", got[1], 64'hBBBB);
      chk("single_f2", got[2], 64'hCCCC);
    end

    // Backpressure on the body flit
    clear_log();
    bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    cycle();
    bus.fifo_rdy = 1'b0;
    run(3);
    bus.fifo_rdy = 1'b1;
    run(4);
    chk("bp_n", got.size(), 3);
    if (got.size() == 3) chk("bp_f1", got[1], 64'hBBBB);

    // Back-to-back offers into a two-entry queue; source holds until accepted
    clear_log();
    pend.push_back(48'h1111_2222_3333);
    pend.push_back(48'h4444_5555_6666);
    pend.push_back(48'h7777_8888_9999);
    exp9 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
             16'h6666, 16'h7777, 16'h8888, 16'h9999};
    for (int i = 0; i < 60 && (pend.size() != 0 || mq.size() != 0); i++) begin
      bus.v_msg_in = (pend.size() != 0);
      bus.msg_in   = (pend.size() != 0) ? pend[0] : '0;
      cycle();
      if (last_acc) void'(pend.pop_front());
    end
    bus.v_msg_in = 1'b0;
    chk("b2b_drained", pend.size() + mq.size(), 0);
    chk("b2b_n", got.size(), 9);
    if (got.size() == 9) begin
      chk("b2b_contig", got_t[8] - got_t[0], 8);
      for (int i = 0; i < 9; i++) chk("b2b_flit", got[i], 64'(exp9[i]));
    end
    run(2);

    // New message accepted in the tail cycle of the only queued message
    bus.msg_in = 48'hA1A1_B2B2_C3C3; bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    run(2);
    bus.msg_in = 48'hD4D4_E5E5_F6F6; bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    chk("tailacc_cnt", bus.msg_cnt, 1);
    chk("tailacc_ctrl", bus.ctrl_out, 2'b01);
    chk("tailacc_flit", bus.flit_out, 16'hD4D4);
    run(4);

    // Reset mid-message
    clear_log();
    bus.msg_in = 48'hAAAA_BBBB_CCCC; bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(3);
    chk("rst_mid_n", got.size(), 1);
    bus.msg_in = 48'h0102_0304_0506; bus.v_msg_in = 1'b1;
    cycle();
    bus.v_msg_in = 1'b0;
    chk("rst_mid_head", bus.ctrl_out, 2'b01);
    run(4);

    // Parameter variant: 8-bit flits, 4 per message
    bus_b.msg_in = 32'h1234_5678; bus_b.v_msg_in = 1'b1;
    cycle();
    bus_b.v_msg_in = 1'b0;
    chk("b_cnt", bus_b.msg_cnt, 1);
    chk("b_f0", bus_b.flit_out, 8'h12); chk("b_c0", bus_b.ctrl_out, 2'b01);
    chk("b_v0", bus_b.v_flit_out, 1);
    cycle();
    chk("b_f1", bus_b.flit_out, 8'h34); chk("b_c1", bus_b.ctrl_out, 2'b10);
    cycle();
    chk("b_f2", bus_b.flit_out, 8'h56); chk("b_c2", bus_b.ctrl_out, 2'b10);
    cycle();
    chk("b_f3", bus_b.flit_out, 8'h78); chk("b_c3", bus_b.ctrl_out, 2'b11);
    cycle();
    chk("b_idle_ctrl", bus_b.ctrl_out, 2'b00);
    chk("b_idle_busy", bus_b.upload_busy, 0);

    // Randomized traffic with backpressure and occasional reset
    rpend = 0;
    rmsg  = '0;
    for (int i = 0; i < 600; i++) begin
      if (!rpend && $urandom_range(0, 2) == 0) begin
        rpend = 1;
        rmsg  = {16'($urandom), 32'($urandom)};
      end
      bus.v_msg_in = rpend;
      bus.msg_in   = rmsg;
      bus.fifo_rdy = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 149) == 0);
      cycle();
      if (last_acc) rpend = 0;
    end
    rst = 1'b0;
    bus.v_msg_in = 1'b0;
    bus.fifo_rdy = 1'b1;
    run(12);
    chk("final_empty", bus.upload_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
